// File: rtl/assoc_cache.sv
// Set-associative write-back, write-allocate cache with round-robin replacement.
// One CPU word port in front of a block-wide memory port; misses stall via busywait.
module assoc_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int WORDS  = 4,
  localparam int OFF_B  = $clog2(DATA_W / 8),
  localparam int WOFF_B = $clog2(WORDS),
  localparam int IDX_B  = $clog2(SETS),
  localparam int TAG_B  = ADDR_W - IDX_B - WOFF_B - OFF_B,
  localparam int MA_W   = ADDR_W - WOFF_B - OFF_B,
  localparam int BLK_W  = DATA_W * WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MA_W-1:0]   mem_address,
  output logic [BLK_W-1:0]  mem_writedata,
  input  logic [BLK_W-1:0]  mem_readdata,
  input  logic              mem_busywait,
  output logic [1:0]        o_dbg_state
);

  localparam int WAY_B = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Handshake: the CPU holds read/write/address/writedata stable while busywait
  // is high; a memory transfer completes on the first rising edge where a strobe
  // is high and mem_busywait is low.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_valid  [SETS][WAYS];
  logic              r_dirty  [SETS][WAYS];
  logic [TAG_B-1:0]  r_tag    [SETS][WAYS];
  logic [BLK_W-1:0]  r_data   [SETS][WAYS];
  logic [WAY_B-1:0]  r_ptr    [SETS];
  logic [WAY_B-1:0]  r_victim;

  logic [TAG_B-1:0]  w_tag;
  logic [IDX_B-1:0]  w_idx;
  logic [WOFF_B-1:0] w_woff;
  logic              w_req;
  logic              w_hit;
  logic [WAY_B-1:0]  w_hit_way;
  logic [WAY_B-1:0]  w_victim;
  logic [BLK_W-1:0]  w_hit_blk;
  logic              w_write_hit;
  logic              w_alloc_done;
  logic [WAY_B-1:0]  w_ptr_next;
  logic              w_unused_addr;

  assign w_tag         = address[ADDR_W-1 -: TAG_B];
  assign w_idx         = address[OFF_B+WOFF_B +: IDX_B];
  assign w_woff        = address[OFF_B +: WOFF_B];
  assign w_unused_addr = ^address[OFF_B-1:0];
  assign w_req         = read | write;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_B'(w);
      end
    end
  end

  // Scanning downward leaves the lowest-numbered invalid way as the winner.
  always_comb begin
    w_victim = r_ptr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_victim = WAY_B'(w);
    end
  end

  assign w_hit_blk     = r_data[w_idx][w_hit_way];
  assign readdata      = w_hit ? w_hit_blk[w_woff*DATA_W +: DATA_W] : '0;
  assign mem_writedata = r_data[w_idx][r_victim];
  assign mem_address   = (r_state == S_WRITEBACK) ? {r_tag[w_idx][r_victim], w_idx}
                                                  : {w_tag, w_idx};
  assign o_dbg_state   = r_state;

  assign w_write_hit  = (r_state == S_IDLE) && write && w_hit;
  assign w_alloc_done = (r_state == S_ALLOCATE) && !mem_busywait;
  assign w_ptr_next   = (WAYS == 1) ? '0 : r_ptr[w_idx] + WAY_B'(1);

  always_comb begin
    w_next    = r_state;
    busywait  = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        busywait = w_req && !w_hit;
        if (w_req && !w_hit) begin
          w_next = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_WRITEBACK
                                                                          : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        if (!mem_busywait) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
        if (!mem_busywait) w_next = S_UPDATE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_victim <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (w_next != S_IDLE)) r_victim <= w_victim;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else if (w_alloc_done) begin
      r_valid[w_idx][r_victim] <= 1'b1;
      r_dirty[w_idx][r_victim] <= 1'b0;
      r_ptr[w_idx]             <= w_ptr_next;
    end else if (w_write_hit) begin
      r_dirty[w_idx][w_hit_way] <= 1'b1;
    end
  end

  // Tags and data are left untouched by reset; the cleared valid bits hide them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_alloc_done) begin
        r_tag[w_idx][r_victim]  <= w_tag;
        r_data[w_idx][r_victim] <= mem_readdata;
      end else if (w_write_hit) begin
        r_data[w_idx][w_hit_way][w_woff*DATA_W +: DATA_W] <= writedata;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: flat word-level golden memory feeds a read scoreboard,
// plus a latency-programmable block memory model and transfer monitors.
module tb_assoc_cache;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int MA_W   = 28;
  localparam int BLK_W  = DATA_W * WORDS;

  logic              clk = 1'b0;
  logic              reset;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;
  logic              mem_read;
  logic              mem_write;
  logic [MA_W-1:0]   mem_address;
  logic [BLK_W-1:0]  mem_writedata;
  logic [BLK_W-1:0]  mem_readdata;
  logic              mem_busywait;
  logic [1:0]        dbg_state;

  assoc_cache #(.ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] gold [logic [31:0]];
  logic [BLK_W-1:0]  mem_model [logic [MA_W-1:0]];

  int              mem_lat = 3;
  int              mcnt = 0;
  int              wb_done = 0;
  int              alloc_done = 0;
  logic [MA_W-1:0] wb_addr = '0;
  logic [BLK_W-1:0] wb_data = '0;
  logic [MA_W-1:0] alloc_addr = '0;
  int              both_cnt = 0;
  int              wb_run = 0;
  int              unstable = 0;
  logic            wb_prev = 1'b0;
  logic [MA_W-1:0] hold_a = '0;
  logic [BLK_W-1:0] hold_d = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (gold.exists(k)) return gold[k];
    return pat(a);
  endfunction

  function automatic logic [BLK_W-1:0] mem_blk(input logic [MA_W-1:0] ba);
    logic [BLK_W-1:0] b;
    logic [3:0]       wo;
    if (mem_model.exists(ba)) return mem_model[ba];
    for (int i = 0; i < WORDS; i++) begin
      wo = 4'(i * 4);
      b[i*32 +: 32] = pat({ba, wo});
    end
    return b;
  endfunction

  // Block memory: busy for mem_lat cycles of a strobe, then completes.
  assign mem_busywait = (mem_read || mem_write) && (mcnt < mem_lat);

  always @(posedge clk) begin
    if (reset || !(mem_read || mem_write) || !mem_busywait) mcnt <= 0;
    else mcnt <= mcnt + 1;
    mem_readdata <= mem_blk(mem_address);
    if (!reset && mem_write && !mem_busywait) begin
      wb_done <= wb_done + 1;
      wb_addr <= mem_address;
      wb_data <= mem_writedata;
      mem_model[mem_address] = mem_writedata;
    end
    if (!reset && mem_read && !mem_busywait) begin
      alloc_done <= alloc_done + 1;
      alloc_addr <= mem_address;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (dbg_state == 2'd1) begin
      if (wb_prev) begin
        if (mem_address != hold_a || mem_writedata != hold_d || !busywait) unstable <= unstable + 1;
        wb_run <= wb_run + 1;
      end else begin
        hold_a <= mem_address;
        hold_d <= mem_writedata;
        wb_run <= 1;
      end
      wb_prev <= 1'b1;
    end else begin
      wb_prev <= 1'b0;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic first_busy);
    int cyc;
    logic [31:0] exp;
    read = rd; write = wr; address = a; writedata = d;
    exp = '0;
    if (wr) gold[{a[31:2], 2'b00}] = d;
    else exp_q.push_back(gold_rd(a));
    #1;
    first_busy = busywait;
    @(negedge clk);
    cyc = 0;
    while (busywait && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!wr) exp = exp_q.pop_front();
    if (busywait) check_eq("access_timeout", 32'(busywait), 32'd0);
    else if (!wr) check_eq("readdata", readdata, exp);
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic fb;
    int a0, w0, cyc;
    logic [23:0] rt;
    logic [3:0]  rs;
    logic [1:0]  rw;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busywait", 32'(busywait), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_readdata", readdata, 32'd0);

    // Cold read miss goes straight to ALLOCATE
    a0 = alloc_done; w0 = wb_done;
    access(1'b1, 1'b0, 32'h8000_0198, 32'd0, fb);
    check_eq("cold_miss_busy", 32'(fb), 32'd1);
    check_eq("cold_no_wb", wb_done, w0);
    check_eq("cold_alloc", alloc_done, a0 + 1);
    check_eq("cold_alloc_addr", 32'(alloc_addr), 32'h0800_0019);

    a0 = alloc_done;
    access(1'b1, 1'b0, 32'h8000_0190, 32'd0, fb);
    check_eq("hit_no_busy", 32'(fb), 32'd0);
    check_eq("hit_no_mem_read", alloc_done, a0);

    @(negedge clk);
    check_eq("noreq_busy", 32'(busywait), 32'd0);
    check_eq("noreq_state", 32'(dbg_state), 32'd0);

    // Write miss into the invalid way, then write hit
    a0 = alloc_done; w0 = wb_done;
    access(1'b0, 1'b1, 32'h0000_0098, 32'hDEAD_BEEF, fb);
    check_eq("wmiss_busy", 32'(fb), 32'd1);
    check_eq("wmiss_no_wb", wb_done, w0);
    check_eq("wmiss_alloc", alloc_done, a0 + 1);
    access(1'b1, 1'b0, 32'h0000_0098, 32'd0, fb);
    check_eq("wdata_hit", 32'(fb), 32'd0);

    // Clean victim at pointer, then dirty victim
    w0 = wb_done;
    access(1'b1, 1'b0, 32'h0001_0098, 32'd0, fb);
    check_eq("clean_victim_no_wb", wb_done, w0);
    access(1'b1, 1'b0, 32'h0002_0098, 32'd0, fb);
    check_eq("dirty_victim_wb", wb_done, w0 + 1);
    check_eq("wb_addr", 32'(wb_addr), 32'h0000_0009);
    check_eq("wb_word2", wb_data[95:64], 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h0000_0098, 32'd0, fb);
    check_eq("refill_no_wb", wb_done, w0 + 1);

    // Long writeback stall
    access(1'b0, 1'b1, 32'h0000_0030, 32'h1111_2222, fb);
    access(1'b0, 1'b1, 32'h0000_1030, 32'h3333_4444, fb);
    w0 = wb_done;
    mem_lat = 10;
    access(1'b1, 1'b0, 32'h0000_2030, 32'd0, fb);
    mem_lat = 3;
    check_eq("stall_wb", wb_done, w0 + 1);
    check_eq("stall_wb_addr", 32'(wb_addr), 32'h0000_0003);
    check_eq("stall_wb_word0", wb_data[31:0], 32'h1111_2222);
    check_eq("stall_wb_cycles", wb_run, 11);
    check_eq("stall_stable", unstable, 0);
    access(1'b1, 1'b0, 32'h0000_0030, 32'd0, fb);

    // Both strobes high behaves as a write
    access(1'b1, 1'b1, 32'h0000_0074, 32'hCAFE_F00D, fb);
    access(1'b1, 1'b1, 32'h0000_0070, 32'h0BAD_CAFE, fb);
    check_eq("both_hit_no_busy", 32'(fb), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0074, 32'd0, fb);
    access(1'b1, 1'b0, 32'h0000_0070, 32'd0, fb);

    // Random traffic over four tags in two sets
    for (int i = 0; i < 60; i++) begin
      mem_lat = $urandom_range(1, 4);
      rt = 24'($urandom_range(0, 3));
      rs = 4'($urandom_range(10, 11));
      rw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        access(1'b1, 1'b0, {rt, rs, rw, 2'b00}, 32'd0, fb);
      else
        access(1'b0, 1'b1, {rt, rs, rw, 2'b00}, $urandom, fb);
    end
    mem_lat = 3;
    check_eq("never_both_strobes", both_cnt, 0);

    // Reset in the middle of ALLOCATE
    read = 1'b1; write = 1'b0; address = 32'h8000_0198;
    @(negedge clk);
    cyc = 0;
    while (dbg_state != 2'd2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reached_alloc", 32'(dbg_state), 32'd2);
    reset = 1'b1; read = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_alloc_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_alloc_busy", 32'(busywait), 32'd0);
    check_eq("rst_alloc_state", 32'(dbg_state), 32'd0);
    a0 = alloc_done;
    access(1'b1, 1'b0, 32'h8000_0198, 32'd0, fb);
    check_eq("reread_miss_busy", 32'(fb), 32'd1);
    check_eq("reread_alloc", alloc_done, a0 + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
